// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem req/gnt/rvalid fetch, one-entry skid, IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN: misaligned pc raises adelId and parks the stage in HALT until flush.
module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic        stallId,
    input  logic        flush,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        pcAdvance,
    output logic [31:0] instrId,
    output logic [31:0] pcId,
    output logic [31:0] pc4Id,
    output logic        validId,
    output logic        adelId,
    output logic [2:0]  fsmState
);

    // Handshake: a fetch is accepted when imemReq && imemGnt in the same cycle; exactly one
    // imemRvalid follows per accepted fetch, at least one cycle later.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
`ifdef FETCH_ALIGN_CHECK_EN
        S_HALT = 3'd4,
`endif
        S_FULL = 3'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] req_pc;
    logic [31:0] req_pc4;
    logic [31:0] skid_data;
    logic        kill;
    logic        if_free;
    logic        misaligned;
    logic        load_rsp;
    logic        load_skid;
    logic        store_skid;
    logic        kill_set;
    logic        kill_clr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        load_adel;
    logic        adel_q;
    assign misaligned = (pc[1:0] != 2'b00);
    assign adelId     = adel_q;
`else
    assign misaligned = 1'b0;
    assign adelId     = 1'b0;
`endif

    assign if_free  = !validId || !stallId;
    assign imemAddr = {pc[31:2], 2'b00};
    assign fsmState = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (!flush && if_free) state_next = S_HALT;
`endif
                end else if (!flush && imemGnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imemRvalid) begin
                    if (!kill && !flush && !if_free) state_next = S_FULL;
                    else                             state_next = S_REQ;
                end
            end
            S_FULL: begin
                if (flush || !stallId) state_next = S_REQ;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_HALT: begin
                if (flush) state_next = S_REQ;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imemReq    = 1'b0;
        pcAdvance  = 1'b0;
        load_rsp   = 1'b0;
        load_skid  = 1'b0;
        store_skid = 1'b0;
        kill_set   = 1'b0;
        kill_clr   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        load_adel  = 1'b0;
`endif
        case (state)
            S_REQ: begin
                if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    load_adel = !flush && if_free;
`endif
                end else begin
                    imemReq   = !flush;
                    pcAdvance = !flush && imemGnt;
                end
            end
            S_WAIT: begin
                if (imemRvalid) begin
                    if (kill || flush) kill_clr   = 1'b1;
                    else if (if_free)  load_rsp   = 1'b1;
                    else               store_skid = 1'b1;
                end else if (flush) begin
                    // response still in flight: remember to discard it
                    kill_set = 1'b1;
                end
            end
            S_FULL: load_skid = !flush && !stallId;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc    <= 32'h0;
            req_pc4   <= 32'h0;
            skid_data <= 32'h0;
            kill      <= 1'b0;
        end else begin
            if (pcAdvance) begin
                req_pc  <= pc;
                req_pc4 <= pc4;
            end
            if (store_skid) skid_data <= imemRdata;
            if (kill_clr)      kill <= 1'b0;
            else if (kill_set) kill <= 1'b1;
        end
    end

    // flush outranks every load and the stall hold
    always_ff @(posedge clk) begin
        if (rst) begin
            instrId <= NOP_INSTR;
            pcId    <= 32'h0;
            pc4Id   <= 32'h0;
            validId <= 1'b0;
        end else if (flush) begin
            instrId <= NOP_INSTR;
            validId <= 1'b0;
        end else if (load_rsp) begin
            instrId <= imemRdata;
            pcId    <= req_pc;
            pc4Id   <= req_pc4;
            validId <= 1'b1;
        end else if (load_skid) begin
            instrId <= skid_data;
            pcId    <= req_pc;
            pc4Id   <= req_pc4;
            validId <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        end else if (load_adel) begin
            instrId <= NOP_INSTR;
            pcId    <= pc;
            pc4Id   <= pc4;
            validId <= 1'b1;
`endif
        end else if (!stallId) begin
            instrId <= NOP_INSTR;
            validId <= 1'b0;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else if (flush) begin
            adel_q <= 1'b0;
        end else if (load_rsp || load_skid) begin
            adel_q <= 1'b0;
        end else if (load_adel) begin
            adel_q <= 1'b1;
        end else if (!stallId) begin
            adel_q <= 1'b0;
        end
    end
`endif

endmodule
